// File: rtl/trng_word_arbiter.sv
// Sequences the padlock TRNG core, packs accepted bits MSB-first into words and
// hands them round-robin to requesters, with a sticky repetition-count health test.
module trng_word_arbiter #(
    parameter int WORD_W    = 32,
    parameter int N_REQ     = 2,
    parameter int REP_LIMIT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic              core_en,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  gnt,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    output logic              health_fail
);

    localparam int CNT_W = $clog2(WORD_W);
    localparam int RUN_W = $clog2(REP_LIMIT + 1);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        PRESENT = 2'd2,
        FAIL    = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   bit_cnt_r;
    logic [RUN_W-1:0]   run_cnt_r;
    logic [RUN_W-1:0]   run_next_s;
    logic               last_bit_r;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [IDX_W-1:0]   owner_r;
    logic [IDX_W-1:0]   owner_inc_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic               pick_valid_s;
    logic               owner_req_s;
    logic               accept_s;
    logic               rep_hit_s;
    logic               last_bit_of_word_s;
    logic [N_REQ-1:0]   gnt_r;
    logic [N_REQ-1:0]   gnt_next_s;
    logic [WORD_W-1:0]  word_r;
    logic               core_en_r;
    logic               word_valid_r;
    logic               health_fail_r;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v = '0;
        for (int i = 0; i < N_REQ; i++) begin
            v[i] = (IDX_W'(i) == idx);
        end
        return v;
    endfunction

    // Round-robin pick: first requester at or after the pointer, wrapping.
    always_comb begin
        pick_valid_s = 1'b0;
        pick_idx_s   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pick_idx_s   = (req[(int'(rr_ptr_r) + i) % N_REQ] && !pick_valid_s)
                           ? IDX_W'((int'(rr_ptr_r) + i) % N_REQ) : pick_idx_s;
            pick_valid_s = pick_valid_s | req[(int'(rr_ptr_r) + i) % N_REQ];
        end
    end

    // Bit acceptance and repetition-count lookahead; an owner drop blocks acceptance.
    always_comb begin
        owner_req_s        = req[owner_r];
        owner_inc_s        = IDX_W'((int'(owner_r) + 1) % N_REQ);
        accept_s           = (state_r == FILL) && bit_valid && owner_req_s;
        last_bit_of_word_s = (bit_cnt_r == CNT_W'(WORD_W - 1));
        if (bit_in == last_bit_r) begin
            run_next_s = (run_cnt_r == RUN_W'(REP_LIMIT)) ? run_cnt_r : run_cnt_r + RUN_W'(1);
        end else begin
            run_next_s = RUN_W'(1);
        end
        rep_hit_s = accept_s && (run_next_s == RUN_W'(REP_LIMIT));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; health failure outranks word completion.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = pick_valid_s ? FILL : IDLE;
            FILL: begin
                if (!owner_req_s) begin
                    state_next_s = IDLE;
                end else if (rep_hit_s) begin
                    state_next_s = FAIL;
                end else if (accept_s && last_bit_of_word_s) begin
                    state_next_s = PRESENT;
                end else begin
                    state_next_s = FILL;
                end
            end
            PRESENT: state_next_s = IDLE;
            FAIL:    state_next_s = FAIL;
            default: state_next_s = IDLE;
        endcase
    end

    // Output next values, registered below so every output comes from a flop.
    always_comb begin
        gnt_next_s = '0;
        case (state_r)
            IDLE:    gnt_next_s = pick_valid_s ? onehot(pick_idx_s) : '0;
            FILL:    gnt_next_s = ((state_next_s == FILL) || (state_next_s == PRESENT)) ? gnt_r : '0;
            PRESENT: gnt_next_s = '0;
            FAIL:    gnt_next_s = '0;
            default: gnt_next_s = '0;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_r         <= '0;
            core_en_r     <= 1'b0;
            word_valid_r  <= 1'b0;
            health_fail_r <= 1'b0;
        end else begin
            gnt_r         <= gnt_next_s;
            core_en_r     <= (state_next_s == FILL);
            word_valid_r  <= (state_next_s == PRESENT);
            health_fail_r <= (state_next_s == FAIL);
        end
    end

    // Shift register, counters and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_r     <= '0;
            bit_cnt_r  <= '0;
            run_cnt_r  <= '0;
            last_bit_r <= 1'b0;
            rr_ptr_r   <= '0;
            owner_r    <= '0;
        end else begin
            if ((state_r == IDLE) && pick_valid_s) begin
                word_r    <= '0;
                bit_cnt_r <= '0;
                owner_r   <= pick_idx_s;
            end else if (accept_s) begin
                word_r     <= {word_r[WORD_W-2:0], bit_in};
                bit_cnt_r  <= bit_cnt_r + CNT_W'(1);
                run_cnt_r  <= run_next_s;
                last_bit_r <= bit_in;
            end else begin
                word_r <= word_r;
            end
            if (((state_r == FILL) && !owner_req_s) || (state_r == PRESENT)) begin
                rr_ptr_r <= owner_inc_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    assign gnt         = gnt_r;
    assign core_en     = core_en_r;
    assign word_out    = word_r;
    assign word_valid  = word_valid_r;
    assign health_fail = health_fail_r;

endmodule
